// File: rtl/input_scheduler.sv
// ============================================================================
// Module   : input_scheduler
// Purpose  : Turns key edges and the frame strobe into one-at-a-time move
//            commands over valid/ready; owns the level-dependent gravity timer.
//            Optional macro AUTO_REPEAT_EN adds DAS/ARR repeat on LEFT, RIGHT
//            and SOFT_DOWN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_scheduler #(
`ifdef AUTO_REPEAT_EN
    parameter int DAS_DELAY   = 10,
    parameter int ARR_PERIOD  = 3,
`endif
    parameter int BASE_PERIOD = 40,
    parameter int LEVEL_STEP  = 2,
    parameter int MIN_PERIOD  = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_game,
    input  logic       enable,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_rotate,
    input  logic       key_drop,
    input  logic       key_down,
    input  logic [3:0] level,
    input  logic       lock_event,
    output logic       cmd_valid,
    output logic [2:0] cmd_op,
    input  logic       cmd_ready
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_OFFER = 1'b1
    } state_t;

    localparam logic [2:0] c_op_none   = 3'd0;
    localparam logic [2:0] c_op_left   = 3'd1;
    localparam logic [2:0] c_op_right  = 3'd2;
    localparam logic [2:0] c_op_rotate = 3'd3;
    localparam logic [2:0] c_op_soft   = 3'd4;
    localparam logic [2:0] c_op_drop   = 3'd5;
    localparam logic [2:0] c_op_grav   = 3'd6;

    localparam logic [7:0] c_base = 8'(BASE_PERIOD);
    localparam logic [7:0] c_min  = 8'(MIN_PERIOD);
    localparam logic [7:0] c_step = 8'(LEVEL_STEP);

    // Pending bit i corresponds to opcode i+1.
    function automatic logic [5:0] op_mask(input logic [2:0] op);
        logic [5:0] m;
        m = '0;
        if (op != c_op_none && op <= c_op_grav) begin
            m[op - 3'd1] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [2:0] pick(input logic [5:0] p);
        logic [2:0] op;
        op = c_op_none;
        if      (p[4]) op = c_op_drop;
        else if (p[2]) op = c_op_rotate;
        else if (p[0]) op = c_op_left;
        else if (p[1]) op = c_op_right;
        else if (p[3]) op = c_op_soft;
        else if (p[5]) op = c_op_grav;
        return op;
    endfunction

    state_t     state_q, state_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic [2:0] cmd_op_q, cmd_op_d;
    logic [4:0] keys_q, keys_d;
    logic [5:0] pend_q, pend_d;
    logic [7:0] cnt_q, cnt_d;

    logic [4:0] key_vec;
    logic [4:0] key_rise;
    logic [7:0] step_total;
    logic [7:0] period;
    logic       handshake;
    logic [5:0] acc_mask;
    logic [5:0] rep_mask;
    logic       grav_clear;
    logic       grav_fire;
    logic [5:0] avail;

`ifdef AUTO_REPEAT_EN
    localparam logic [5:0] c_das    = 6'(DAS_DELAY);
    localparam logic [5:0] c_reload = 6'(DAS_DELAY - ARR_PERIOD);

    logic [2:0][5:0] hold_q, hold_d;
    logic [2:0]      rep_keys;
    logic [2:0]      rep_fire;

    // Reload to DAS-ARR after each repeat so the next one lands ARR ticks later.
    always_comb begin
        rep_keys = {key_down, key_right, key_left};
        hold_d   = hold_q;
        rep_fire = '0;
        for (int i = 0; i < 3; i++) begin
            if (!enable || !rep_keys[i]) begin
                hold_d[i] = '0;
            end else if (tick_game) begin
                if (6'(hold_q[i] + 6'd1) == c_das) begin
                    rep_fire[i] = 1'b1;
                    hold_d[i]   = c_reload;
                end else begin
                    hold_d[i] = 6'(hold_q[i] + 6'd1);
                end
            end
        end
        rep_mask = {2'b00, rep_fire[2], 1'b0, rep_fire[1], rep_fire[0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    always_comb begin
        rep_mask = '0;
    end
`endif

    always_comb begin
        key_vec  = {key_drop, key_down, key_rotate, key_right, key_left};
        keys_d   = key_vec;
        key_rise = key_vec & ~keys_q;

        // Subtraction guarded so a large level clamps to the floor instead of wrapping.
        step_total = 8'(level) * c_step;
        if (c_base > step_total && (c_base - step_total) > c_min) begin
            period = c_base - step_total;
        end else begin
            period = c_min;
        end

        handshake  = (state_q == S_OFFER) && cmd_ready;
        acc_mask   = handshake ? op_mask(cmd_op_q) : 6'b0;
        grav_clear = lock_event ||
                     (handshake && (cmd_op_q == c_op_soft || cmd_op_q == c_op_grav));

        grav_fire = 1'b0;
        cnt_d     = cnt_q;
        if (tick_game && !pend_q[5]) begin
            if (cnt_q >= period) begin
                grav_fire = 1'b1;
                cnt_d     = '0;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
        if (grav_clear) begin
            grav_fire = 1'b0;
            cnt_d     = '0;
        end

        pend_d = (pend_q & ~acc_mask) | {1'b0, key_rise} | rep_mask | {grav_fire, 5'b0};
        if (grav_clear) begin
            pend_d[5] = 1'b0;
        end
        if (!enable) begin
            pend_d = '0;
            cnt_d  = '0;
        end

        // A same-cycle lock_event must not let a stale GRAVITY be offered.
        avail = pend_q;
        if (lock_event) begin
            avail[5] = 1'b0;
        end

        state_d     = state_q;
        cmd_valid_d = cmd_valid_q;
        cmd_op_d    = cmd_op_q;
        if (!enable) begin
            state_d     = S_IDLE;
            cmd_valid_d = 1'b0;
            cmd_op_d    = c_op_none;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|avail) begin
                        cmd_op_d    = pick(avail);
                        cmd_valid_d = 1'b1;
                        state_d     = S_OFFER;
                    end
                end
                S_OFFER: begin
                    if (cmd_ready) begin
                        cmd_valid_d = 1'b0;
                        cmd_op_d    = c_op_none;
                        state_d     = S_IDLE;
                    end
                end
                default: begin
                    state_d     = S_IDLE;
                    cmd_valid_d = 1'b0;
                    cmd_op_d    = c_op_none;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cmd_valid_q <= 1'b0;
            cmd_op_q    <= c_op_none;
            keys_q      <= '0;
            pend_q      <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            cmd_valid_q <= cmd_valid_d;
            cmd_op_q    <= cmd_op_d;
            keys_q      <= keys_d;
            pend_q      <= pend_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cmd_valid = cmd_valid_q;
    assign cmd_op    = cmd_op_q;

endmodule

`default_nettype wire
